reg_dump_reader: RTL and testbench
==================================

// Module: reg_dump_reader
// PURPOSE
//  - Read-side companion to the 32x32 register file: sweeps an address range over one
//    read port and streams each word out on a valid/ready interface.
//  - Used for debug dump / end-of-test state check of the MIPS core; drives Read_addr_*
//    of a spare or muxed port; never writes the register file.
// PARAMETERS
//  - ADDR_W    5   register address width (register count = 2**ADDR_W)
//  - DATA_W    32  register data width
// PORTS
//  - CLK         in   1       clock, all state on rising edge
//  - RST         in   1       asynchronous reset, active-low
//  - start       in   1       begin dump; sampled only in IDLE
//  - first_addr  in   ADDR_W  first register to dump, latched on accepted start
//  - last_addr   in   ADDR_W  last register to dump, latched on accepted start
//  - rd_addr     out  ADDR_W  read address to register file (Read_addr_A/B)
//  - rd_data     in   DATA_W  combinational read data from register file (RDA/RDB)
//  - out_valid   out  1       out_data/out_addr/out_last valid
//  - out_ready   in   1       sink accepts beat when out_valid & out_ready
//  - out_data    out  DATA_W  dumped register value
//  - out_addr    out  ADDR_W  register index of out_data
//  - out_last    out  1       final beat of dump
//  - busy        out  1       high from accepted start until done
//  - done        out  1       one-cycle pulse after final beat accepted
// BEHAVIOUR
//  - Reset (RST=0, async): state IDLE; rd_addr, out_data, out_addr = 0; out_valid,
//    out_last, busy, done = 0. Reset mid-dump aborts; no done pulse.
//  - FSM IDLE -> READ -> SEND -> (READ | DONE) -> IDLE.
//  - IDLE: start=1 latches first_addr/last_addr, rd_addr<=first_addr, busy<=1, -> READ.
//  - READ: one cycle; rd_data registered into out_data, out_addr<=rd_addr,
//    out_last<=(rd_addr==last_addr) (without CSUM), out_valid<=1, -> SEND.
//  - SEND: out_data/out_addr/out_last held stable while out_valid & !out_ready.
//    On handshake: out_valid<=0; if final beat -> DONE, else rd_addr<=rd_addr+1, -> READ.
//  - DONE: done=1 for exactly one cycle, busy<=0, -> IDLE.
//  - Latency: accepted start -> first out_valid = 2 cycles; min 2 cycles per beat.
//  - Address arithmetic modulo 2**ADDR_W: first_addr>last_addr wraps 31->0;
//    first_addr==last_addr dumps exactly one register.
//  - start while busy ignored; first_addr/last_addr changes after latch ignored.
//  - Register-file writes during a dump are visible if they land before the READ cycle
//    of that address; no snapshot.
// CONFIGURATION
//  - REG_DUMP_CHECKSUM_EN defined: running XOR of all emitted register words (cleared on
//    accepted start); after the last register beat one extra beat with out_data=XOR,
//    out_addr=0, out_last=1; out_last is 0 on all register beats.
//  - Undefined: no checksum logic, out_last on last register beat, no extra beat.
// TESTING
//  - Reset: RST=0 mid-SEND -> all outputs 0 immediately, IDLE; next start works normally.
//  - Range 0..3, out_ready=1, R2=32'hA5A5_0002, R3=32'h0000_0003 -> beats (0,0),(1,1),
//    (2,A5A50002),(3,3), out_last on addr 3, done 1 cycle after.
//  - Backpressure: out_ready=0 for 5 cycles on beat addr 1 -> out_data=1, out_addr=1
//    held stable, rd_addr unchanged; resumes on out_ready=1.
//  - Wrap: first=30, last=1 -> addrs 30,31,0,1 in order, out_last on 1.
//  - Single/ignored start: first=last=5 -> one beat, out_last=1; start pulsed while busy
//    -> no effect, beat count unchanged.
//  - REG_DUMP_CHECKSUM_EN: range 0..3 with values above -> 5th beat out_data=32'hA5A50000
//    (0^1^A5A50002^3), out_addr=0, out_last=1.

Source files
------------

// File: rtl/reg_dump_reader.sv
// Register-file dump engine: sweeps first_addr..last_addr (modulo 2**ADDR_W) on one read
// port and streams each word over valid/ready. Optional trailing XOR beat: REG_DUMP_CHECKSUM_EN.
module reg_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, SEND, SUM, FINISH} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, SEND, FINISH} state_t;
`endif

  state_t            state;
  logic [ADDR_W-1:0] last_q;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
  // out_last is reserved for the checksum beat, so the final register beat is tracked here
  logic              final_q;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      last_q    <= '0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum      <= '0;
      final_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            last_q  <= last_addr;
            rd_addr <= first_addr;
            busy    <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            csum    <= '0;
`endif
            state   <= READ;
          end
        end
        READ: begin
          out_data  <= rd_data;
          out_addr  <= rd_addr;
          out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          csum      <= csum ^ rd_data;
          final_q   <= (rd_addr == last_q);
          out_last  <= 1'b0;
`else
          out_last  <= (rd_addr == last_q);
`endif
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            if (final_q) begin
              // csum already folds in the word being accepted now
              out_data  <= csum;
              out_addr  <= '0;
              out_last  <= 1'b1;
              out_valid <= 1'b1;
              state     <= SUM;
            end
`else
            if (out_last) begin
              done  <= 1'b1;
              state <= FINISH;
            end
`endif
            else begin
              rd_addr <= rd_addr + ADDR_W'(1);
              state   <= READ;
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        SUM: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= FINISH;
          end
        end
`endif
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader with a behavioural 32x32 register file on the read port.
// Expectations follow REG_DUMP_CHECKSUM_EN when that macro is defined.
module tb_reg_dump_reader;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  first_addr = '0;
  logic [4:0]  last_addr = '0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_addr;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] regs [0:31];
  assign rd_data = regs[rd_addr];

  int checks = 0;
  int errors = 0;

  logic [4:0]  b_addr [$];
  logic [31:0] b_data [$];
  logic        b_last [$];
  int          done_cnt;

  reg_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic kick(input logic [4:0] f, input logic [4:0] l);
    @(posedge CLK); #1;
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic collect(input int budget);
    b_addr.delete(); b_data.delete(); b_last.delete();
    done_cnt = 0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid && out_ready) begin
        b_addr.push_back(out_addr);
        b_data.push_back(out_data);
        b_last.push_back(out_last);
      end
      if (done) begin
        done_cnt++;
        break;
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({out_valid, out_last, busy, done} !== 4'b0 || rd_addr !== 5'd0 || out_data !== 32'd0 || out_addr !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got v=%b l=%b b=%b d=%b ra=%0d od=%h oa=%0d, want all 0",
               out_valid, out_last, busy, done, rd_addr, out_data, out_addr);
    end
    RST = 1'b1;
    out_ready = 1'b0;
    kick(5'd2, 5'd3);
    @(posedge CLK); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0002 || rd_addr !== 5'd2) begin
      errors++;
      $display("[TB] FAIL pre_reset_beat: got v=%b od=%h ra=%0d, want v=1 od=a5a50002 ra=2",
               out_valid, out_data, rd_addr);
    end
    RST = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, busy, done} !== 4'b0 || rd_addr !== 5'd0 || out_data !== 32'd0 || out_addr !== 5'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got v=%b l=%b b=%b d=%b ra=%0d od=%h oa=%0d, want all 0",
               out_valid, out_last, busy, done, rd_addr, out_data, out_addr);
    end
    #2;
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_abort: got done=%b busy=%b, want 0 0", done, busy);
      end
    end
  endtask

  task automatic test_range;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [4:0]  ea [5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd0};
    logic [31:0] ed [5] = '{32'd0, 32'd1, 32'hA5A5_0002, 32'd3, 32'hA5A5_0000};
    logic        el [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          n = 5;
`else
    logic [4:0]  ea [4] = '{5'd0, 5'd1, 5'd2, 5'd3};
    logic [31:0] ed [4] = '{32'd0, 32'd1, 32'hA5A5_0002, 32'd3};
    logic        el [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int          n = 4;
`endif
    out_ready = 1'b1;
    kick(5'd0, 5'd3);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_read: got v=%b busy=%b, want v=0 busy=1", out_valid, busy);
    end
    @(posedge CLK); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_first: got v=%b, want 1", out_valid);
    end
    collect(100);
    checks++;
    if (done_cnt != 1 || b_addr.size() != n) begin
      errors++;
      $display("[TB] FAIL range_count: got beats=%0d done=%0d, want beats=%0d done=1",
               b_addr.size(), done_cnt, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (b_addr[i] !== ea[i] || b_data[i] !== ed[i] || b_last[i] !== el[i]) begin
          errors++;
          $display("[TB] FAIL range_beat%0d: got (%0d,%h,%b), want (%0d,%h,%b)",
                   i, b_addr[i], b_data[i], b_last[i], ea[i], ed[i], el[i]);
        end
      end
    end
    @(posedge CLK); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_pulse: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure;
    int  beats = 0;
    bit  stalled = 0;
    bit  finished = 0;
`ifdef REG_DUMP_CHECKSUM_EN
    int  want = 4;
`else
    int  want = 3;
`endif
    out_ready = 1'b1;
    kick(5'd0, 5'd2);
    for (int i = 0; i < 100; i++) begin
      if (out_valid && out_addr == 5'd1 && !stalled && !out_last) begin
        stalled   = 1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge CLK); #1;
          checks++;
          if (out_valid !== 1'b1 || out_data !== 32'd1 || out_addr !== 5'd1 || rd_addr !== 5'd1) begin
            errors++;
            $display("[TB] FAIL stall_hold%0d: got v=%b od=%h oa=%0d ra=%0d, want v=1 od=1 oa=1 ra=1",
                     k, out_valid, out_data, out_addr, rd_addr);
          end
        end
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) beats++;
      if (done) begin
        finished = 1;
        break;
      end
      @(posedge CLK); #1;
    end
    checks++;
    if (!stalled || !finished || beats != want) begin
      errors++;
      $display("[TB] FAIL stall_resume: got stalled=%0d done=%0d beats=%0d, want 1 1 %0d",
               stalled, finished, beats, want);
    end
  endtask

  task automatic test_wrap;
    logic [4:0] ea [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
    logic [31:0] ed [4] = '{32'd30, 32'd31, 32'd0, 32'd1};
`ifdef REG_DUMP_CHECKSUM_EN
    logic        el [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int          n = 5;
`else
    logic        el [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int          n = 4;
`endif
    out_ready = 1'b1;
    kick(5'd30, 5'd1);
    collect(100);
    checks++;
    if (done_cnt != 1 || b_addr.size() != n) begin
      errors++;
      $display("[TB] FAIL wrap_count: got beats=%0d done=%0d, want beats=%0d done=1",
               b_addr.size(), done_cnt, n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (b_addr[i] !== ea[i] || b_data[i] !== ed[i] || b_last[i] !== el[i]) begin
          errors++;
          $display("[TB] FAIL wrap_beat%0d: got (%0d,%h,%b), want (%0d,%h,%b)",
                   i, b_addr[i], b_data[i], b_last[i], ea[i], ed[i], el[i]);
        end
      end
    end
  endtask

  task automatic test_single_ignored;
`ifdef REG_DUMP_CHECKSUM_EN
    int n = 2;
    logic l0 = 1'b0;
`else
    int n = 1;
    logic l0 = 1'b1;
`endif
    out_ready = 1'b1;
    kick(5'd5, 5'd5);
    first_addr = 5'd0;
    last_addr  = 5'd3;
    start      = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    collect(100);
    checks++;
    if (done_cnt != 1 || b_addr.size() != n) begin
      errors++;
      $display("[TB] FAIL single_count: got beats=%0d done=%0d, want beats=%0d done=1",
               b_addr.size(), done_cnt, n);
    end else begin
      checks++;
      if (b_addr[0] !== 5'd5 || b_data[0] !== 32'd5 || b_last[0] !== l0) begin
        errors++;
        $display("[TB] FAIL single_beat: got (%0d,%h,%b), want (5,00000005,%b)",
                 b_addr[0], b_data[0], b_last[0], l0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ignored_start: got v=%b busy=%b, want 0 0", out_valid, busy);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    regs[2] = 32'hA5A5_0002;
    test_reset;
    test_range;
    test_backpressure;
    test_wrap;
    test_single_ignored;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
